// File: rtl/sop_eval_seq.sv
// Serial sum-of-products evaluator: one masked product term per clock, OR-accumulated,
// with a start/busy/done handshake and per-term hit flags.
module sop_eval_seq #(
    parameter int unsigned IN_W       = 4,
    parameter int unsigned TERMS      = 2,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       in_vec,
    input  logic [TERMS*IN_W-1:0] mask_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  y,
    output logic [TERMS-1:0]      term_hits
);

    localparam int unsigned   IdxW    = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(TERMS - 1);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IN_W-1:0]         in_q, in_d;
    logic [TERMS*IN_W-1:0]   mask_q, mask_d;
    logic                    acc_q, acc_d;
    logic [TERMS-1:0]        shadow_q, shadow_d;
    logic                    y_q, y_d;
    logic [TERMS-1:0]        hits_q, hits_d;

    logic [IN_W-1:0]         cur_mask;
    logic                    hit;
    logic [TERMS-1:0]        hit_vec;

    // Current-term mask mux and one-hot placement of its hit flag.
    always_comb begin
        cur_mask = '0;
        hit_vec  = '0;
        for (int unsigned t = 0; t < TERMS; t++) begin
            if (idx_q == IdxW'(t)) begin
                cur_mask = mask_q[t*IN_W +: IN_W];
            end
        end
        // An all-zero mask disables the term rather than making it trivially true.
        hit = (|cur_mask) && ((in_q & cur_mask) == cur_mask);
        for (int unsigned t = 0; t < TERMS; t++) begin
            if (idx_q == IdxW'(t)) begin
                hit_vec[t] = hit;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_d     = in_q;
        mask_d   = mask_q;
        acc_d    = acc_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        hits_d   = hits_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StEval;
                    in_d     = in_vec;
                    mask_d   = mask_flat;
                    idx_d    = '0;
                    acc_d    = 1'b0;
                    shadow_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StEval: begin
                acc_d    = acc_q | hit;
                shadow_d = shadow_q | hit_vec;
                if ((idx_q == LastIdx) || (EARLY_EXIT && hit)) begin
                    state_d = StDone;
                    y_d     = acc_d;
                    hits_d  = shadow_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            in_q     <= '0;
            mask_q   <= '0;
            acc_q    <= 1'b0;
            shadow_q <= '0;
            y_q      <= 1'b0;
            hits_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            in_q     <= in_d;
            mask_q   <= mask_d;
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            hits_q   <= hits_d;
        end
    end

    assign busy      = (state_q == StEval);
    assign done      = (state_q == StDone);
    assign y         = y_q;
    assign term_hits = hits_q;

endmodule
